// File: rtl/sdram_pattern_tester.sv
`timescale 1ns/1ps
// sdram_pattern_tester: self-running write/readback pattern test in front of the SDRAM
// controller. Writes a pattern over [addr_lo..addr_hi], reads it back and records miscompares.
module sdram_pattern_tester #(
   parameter int                ADDR_W       = 24,
   parameter int                DATA_W       = 16,
   parameter int                ERR_CNT_W    = 16,
   parameter int                BUSY_TIMEOUT = 255,
   parameter bit                STOP_ON_ERR  = 1'b0,
   parameter logic [DATA_W-1:0] LFSR_TAPS    = 16'hB400
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 abort,
   input  logic [1:0]           mode,
   input  logic [DATA_W-1:0]    seed,
   input  logic [ADDR_W-1:0]    addr_lo,
   input  logic [ADDR_W-1:0]    addr_hi,
   output logic                 wt_start_trig,
   input  logic                 wt_busy_flag,
   output logic [ADDR_W-1:0]    WT_ADR,
   output logic [DATA_W-1:0]    WT_DATA,
   output logic                 rd_start_trig,
   input  logic                 rd_busy_flag,
   output logic [ADDR_W-1:0]    RD_ADR,
   input  logic [DATA_W-1:0]    RD_DATA,
   output logic                 running,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic                 cfg_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    err_adr,
   output logic [DATA_W-1:0]    err_exp,
   output logic [DATA_W-1:0]    err_got,
   output logic [ADDR_W-1:0]    cur_adr
);

   localparam int                TMR_W    = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
   localparam logic [DATA_W-1:0] CHK_ODD  = {(DATA_W/2){2'b01}};
   localparam logic [DATA_W-1:0] CHK_EVEN = {(DATA_W/2){2'b10}};

   typedef enum logic [3:0] {
      IDLE, WR_REQ, WR_ACK, WR_DONE, RD_REQ, RD_ACK, RD_DONE, RD_CMP, DONE
   } state_t;

   state_t               state, state_nxt;
   logic [ADDR_W-1:0]    lo_r, hi_r;
   logic [1:0]           mode_r;
   logic [DATA_W-1:0]    seed_r, seed_fix;
   logic [DATA_W-1:0]    lfsr, lfsr_nxt;
   logic [TMR_W-1:0]     timer;
   logic [DATA_W-1:0]    addr_pat, walk, pat;
   logic [ADDR_W-1:0]    bit_idx;
   logic                 last, tmr_exp, miscmp, cfg_bad;

   // Address pattern: low address bits, zero-extended when the address is narrower.
   generate
      if (ADDR_W >= DATA_W) begin : g_apat_trunc
         assign addr_pat = cur_adr[DATA_W-1:0];
      end else begin : g_apat_ext
         assign addr_pat = {{(DATA_W-ADDR_W){1'b0}}, cur_adr};
      end
   endgenerate

   assign bit_idx  = cur_adr % ADDR_W'(DATA_W);
   assign walk     = DATA_W'(1) << bit_idx;
   assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
   assign seed_fix = (seed == '0) ? DATA_W'(1) : seed;

   always_comb begin
      pat = addr_pat;
      case (mode_r)
         2'd1:    pat = walk;
         2'd2:    pat = cur_adr[0] ? CHK_ODD : CHK_EVEN;
         2'd3:    pat = lfsr;
         default: pat = addr_pat;
      endcase
   end

   assign last    = (cur_adr == hi_r);
   assign tmr_exp = (timer == TMR_LAST);
   assign miscmp  = (RD_DATA != pat);
   assign cfg_bad = (addr_lo > addr_hi);

   assign wt_start_trig = (state == WR_REQ);
   assign rd_start_trig = (state == RD_REQ);
   assign WT_ADR        = cur_adr;
   assign RD_ADR        = cur_adr;
   assign WT_DATA       = pat;
   assign running       = (state != IDLE) && (state != DONE);

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start) state_nxt = cfg_bad ? DONE : WR_REQ;
            WR_REQ:     state_nxt = WR_ACK;
            WR_ACK: begin
               if (wt_busy_flag) state_nxt = WR_DONE;
               else if (tmr_exp) state_nxt = DONE;
            end
            WR_DONE: begin
               if (!wt_busy_flag) state_nxt = last ? RD_REQ : WR_REQ;
               else if (tmr_exp)  state_nxt = DONE;
            end
            RD_REQ:     state_nxt = RD_ACK;
            RD_ACK: begin
               if (rd_busy_flag) state_nxt = RD_DONE;
               else if (tmr_exp) state_nxt = DONE;
            end
            RD_DONE: begin
               if (!rd_busy_flag) state_nxt = RD_CMP;
               else if (tmr_exp)  state_nxt = DONE;
            end
            RD_CMP: begin
               if ((miscmp && STOP_ON_ERR) || last) state_nxt = DONE;
               else                                 state_nxt = RD_REQ;
            end
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         timer   <= '0;
         lo_r    <= '0;
         hi_r    <= '0;
         mode_r  <= '0;
         seed_r  <= DATA_W'(1);
         lfsr    <= DATA_W'(1);
         cur_adr <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
         timeout <= 1'b0;
         cfg_err <= 1'b0;
         err_cnt <= '0;
         err_adr <= '0;
         err_exp <= '0;
         err_got <= '0;
      end else begin
         state <= state_nxt;
         // Timer counts cycles spent in the current state; any transition restarts it.
         timer <= (state_nxt != state) ? '0 : timer + TMR_W'(1);
         if (abort) begin
            done <= 1'b0;
            pass <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: if (start) begin
                  lo_r    <= addr_lo;
                  hi_r    <= addr_hi;
                  mode_r  <= mode;
                  seed_r  <= seed_fix;
                  pass    <= 1'b0;
                  timeout <= 1'b0;
                  if (cfg_bad) begin
                     cfg_err <= 1'b1;
                     done    <= 1'b1;
                  end else begin
                     cfg_err <= 1'b0;
                     done    <= 1'b0;
                     err_cnt <= '0;
                     err_adr <= '0;
                     err_exp <= '0;
                     err_got <= '0;
                     cur_adr <= addr_lo;
                     lfsr    <= seed_fix;
                  end
               end
               WR_ACK, RD_ACK: if (!(state == WR_ACK ? wt_busy_flag : rd_busy_flag) && tmr_exp) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
               end
               WR_DONE: begin
                  if (!wt_busy_flag) begin
                     if (last) begin
                        cur_adr <= lo_r;
                        lfsr    <= seed_r;
                     end else begin
                        cur_adr <= cur_adr + ADDR_W'(1);
                        lfsr    <= lfsr_nxt;
                     end
                  end else if (tmr_exp) begin
                     timeout <= 1'b1;
                     done    <= 1'b1;
                  end
               end
               RD_DONE: if (rd_busy_flag && tmr_exp) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
               end
               RD_CMP: begin
                  if (miscmp) begin
                     if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                     // The counter never wraps back to zero, so zero marks "no error yet".
                     if (err_cnt == '0) begin
                        err_adr <= cur_adr;
                        err_exp <= pat;
                        err_got <= RD_DATA;
                     end
                  end
                  if ((miscmp && STOP_ON_ERR) || last) begin
                     done <= 1'b1;
                     pass <= !miscmp && (err_cnt == '0) && !timeout && !cfg_err;
                  end else begin
                     cur_adr <= cur_adr + ADDR_W'(1);
                     lfsr    <= lfsr_nxt;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
`timescale 1ns/1ps
// Directed bench for sdram_pattern_tester: table of full-test vectors against a small
// controller/memory model, plus hand sequences for timeout, abort and start-while-running.
module tb_sdram_pattern_tester;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0, abort = 1'b0;
   logic [1:0]  mode = '0;
   logic [15:0] seed = '0;
   logic [23:0] addr_lo = '0, addr_hi = '0;
   logic        wt_start_trig, wt_busy_flag, rd_start_trig, rd_busy_flag;
   logic [23:0] WT_ADR, RD_ADR, err_adr, cur_adr;
   logic [15:0] WT_DATA, RD_DATA, err_exp, err_got, err_cnt;
   logic        running, done, pass, timeout, cfg_err;

   sdram_pattern_tester dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort), .mode(mode), .seed(seed),
      .addr_lo(addr_lo), .addr_hi(addr_hi),
      .wt_start_trig(wt_start_trig), .wt_busy_flag(wt_busy_flag), .WT_ADR(WT_ADR), .WT_DATA(WT_DATA),
      .rd_start_trig(rd_start_trig), .rd_busy_flag(rd_busy_flag), .RD_ADR(RD_ADR), .RD_DATA(RD_DATA),
      .running(running), .done(done), .pass(pass), .timeout(timeout), .cfg_err(cfg_err),
      .err_cnt(err_cnt), .err_adr(err_adr), .err_exp(err_exp), .err_got(err_got), .cur_adr(cur_adr)
   );

   always #5 CLK = ~CLK;

   // Controller model: busy high for 3 cycles starting 1 cycle after the trigger.
   logic [2:0]  wsh = '0, rsh = '0;
   logic        wt_never = 1'b0;
   logic [7:0]  ca = 8'hFF, cb = 8'hFF;
   logic [15:0] mem [256];
   logic [15:0] rdq = '0;
   logic [15:0] wlog [$];
   int          nrd = 0;

   assign wt_busy_flag = !wt_never && (|wsh);
   assign rd_busy_flag = |rsh;
   assign RD_DATA      = rdq;

   always @(posedge CLK) begin
      wsh <= {wsh[1:0], wt_start_trig};
      rsh <= {rsh[1:0], rd_start_trig};
      if (wt_start_trig) begin
         mem[WT_ADR[7:0]] <= WT_DATA;
         wlog.push_back(WT_DATA);
      end
      if (rd_start_trig) begin
         rdq <= (RD_ADR[7:0] == ca || RD_ADR[7:0] == cb) ? 16'h0000 : mem[RD_ADR[7:0]];
         nrd <= nrd + 1;
      end
   end

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] seed;
      logic [23:0] lo, hi;
      logic [7:0]  ca, cb;
      int          nw;
      logic [15:0] w0, w1, w2, w3;
      logic        cfg, pass;
      int          ecnt;
      logic [23:0] eadr;
      logic [15:0] eexp, egot;
   } vec_t;

   vec_t vt [9];

   task automatic run(input logic [1:0] m, input logic [15:0] sd, input logic [23:0] lo, hi,
                      output int cyc);
      mode = m; seed = sd; addr_lo = lo; addr_hi = hi;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 5000) begin
         @(posedge CLK); #1;
         cyc++;
      end
   endtask

   initial begin
      int cyc, w0, r0, n;
      logic [15:0] wexp [4];

      //            mode seed    lo      hi      ca     cb     nw w0       w1       w2       w3       cfg  pass ecnt eadr    eexp      egot
      vt[0] = '{2'd0, 16'h0, 24'h10, 24'h13, 8'hFF, 8'hFF, 4, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 1'b0, 1'b1, 0, 24'h0, 16'h0,    16'h0};
      vt[1] = '{2'd0, 16'h0, 24'h10, 24'h13, 8'h12, 8'hFF, 4, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 1'b0, 1'b0, 1, 24'h12, 16'h0012, 16'h0};
      vt[2] = '{2'd3, 16'h0, 24'h00, 24'h02, 8'hFF, 8'hFF, 3, 16'h0001, 16'hB400, 16'h5A00, 16'h0000, 1'b0, 1'b1, 0, 24'h0, 16'h0,    16'h0};
      vt[3] = '{2'd1, 16'h0, 24'h0E, 24'h11, 8'hFF, 8'hFF, 4, 16'h4000, 16'h8000, 16'h0001, 16'h0002, 1'b0, 1'b1, 0, 24'h0, 16'h0,    16'h0};
      vt[4] = '{2'd2, 16'h0, 24'h02, 24'h05, 8'hFF, 8'hFF, 4, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 1'b0, 1'b1, 0, 24'h0, 16'h0,    16'h0};
      vt[5] = '{2'd0, 16'h0, 24'h05, 24'h04, 8'hFF, 8'hFF, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 24'h0, 16'h0,    16'h0};
      vt[6] = '{2'd0, 16'h0, 24'h07, 24'h07, 8'h07, 8'hFF, 1, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1, 24'h07, 16'h0007, 16'h0};
      vt[7] = '{2'd3, 16'h3, 24'h00, 24'h01, 8'hFF, 8'hFF, 2, 16'h0003, 16'hB401, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 24'h0, 16'h0,    16'h0};
      vt[8] = '{2'd2, 16'h0, 24'h00, 24'h03, 8'h01, 8'h03, 4, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 2, 24'h01, 16'h5555, 16'h0};

      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_err_adr", err_adr, 0);
      chk("rst_cur_adr", cur_adr, 0);
      chk("rst_wt_trig", wt_start_trig, 0);
      chk("rst_rd_trig", rd_start_trig, 0);
      chk("rst_wt_data", WT_DATA, 0);

      for (int i = 0; i < 9; i++) begin
         ca = vt[i].ca; cb = vt[i].cb;
         wexp[0] = vt[i].w0; wexp[1] = vt[i].w1; wexp[2] = vt[i].w2; wexp[3] = vt[i].w3;
         repeat (5) @(posedge CLK);
         #1;
         w0 = wlog.size(); r0 = nrd;
         run(vt[i].mode, vt[i].seed, vt[i].lo, vt[i].hi, cyc);
         chk($sformatf("v%0d_done", i), done, 1);
         chk($sformatf("v%0d_running", i), running, 0);
         chk($sformatf("v%0d_pass", i), pass, vt[i].pass);
         chk($sformatf("v%0d_cfg_err", i), cfg_err, vt[i].cfg);
         chk($sformatf("v%0d_timeout", i), timeout, 0);
         chk($sformatf("v%0d_err_cnt", i), err_cnt, vt[i].ecnt);
         chk($sformatf("v%0d_writes", i), wlog.size() - w0, vt[i].nw);
         chk($sformatf("v%0d_reads", i), nrd - r0, vt[i].nw);
         for (int k = 0; k < vt[i].nw && k < 4; k++)
            if (wlog.size() > w0 + k)
               chk($sformatf("v%0d_wdata%0d", i, k), wlog[w0 + k], wexp[k]);
         if (vt[i].ecnt != 0) begin
            chk($sformatf("v%0d_err_adr", i), err_adr, vt[i].eadr);
            chk($sformatf("v%0d_err_exp", i), err_exp, vt[i].eexp);
            chk($sformatf("v%0d_err_got", i), err_got, vt[i].egot);
         end
         if (vt[i].cfg) chk($sformatf("v%0d_cfg_latency", i), cyc, 1);
      end
      ca = 8'hFF; cb = 8'hFF;

      // Write busy never rises: 255 cycles in WR_ACK, then DONE with timeout.
      repeat (5) @(posedge CLK);
      #1;
      wt_never = 1'b1;
      w0 = wlog.size(); r0 = nrd;
      run(2'd0, 16'h0, 24'h10, 24'h13, cyc);
      chk("t4_done", done, 1);
      chk("t4_timeout", timeout, 1);
      chk("t4_pass", pass, 0);
      chk("t4_cycles", cyc, 257);
      chk("t4_writes", wlog.size() - w0, 1);
      chk("t4_reads", nrd - r0, 0);
      wt_never = 1'b0;

      // Abort while in WR_DONE at 0x11.
      repeat (5) @(posedge CLK);
      #1;
      mode = 2'd0; addr_lo = 24'h10; addr_hi = 24'h13;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      n = 0;
      while (!(WT_ADR == 24'h11 && wt_busy_flag) && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("t6_reach", (n < 200), 1);
      @(posedge CLK); #1;
      w0 = wlog.size();
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      chk("t6_running", running, 0);
      chk("t6_done", done, 0);
      chk("t6_wt_trig", wt_start_trig, 0);
      repeat (8) @(posedge CLK);
      #1;
      chk("t6_no_writes", wlog.size() - w0, 0);

      // start and abort together: abort wins, nothing starts.
      start = 1'b1; abort = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; abort = 1'b0;
      chk("both_running", running, 0);
      chk("both_wt_trig", wt_start_trig, 0);

      // Full rerun; a start pulse mid-test with other settings must be ignored.
      repeat (3) @(posedge CLK);
      #1;
      w0 = wlog.size();
      mode = 2'd0; addr_lo = 24'h10; addr_hi = 24'h13;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      mode = 2'd2; addr_lo = 24'h40; addr_hi = 24'h41;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 5000) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("rerun_done", done, 1);
      chk("rerun_pass", pass, 1);
      chk("rerun_writes", wlog.size() - w0, 4);
      if (wlog.size() >= w0 + 4) begin
         chk("rerun_wdata0", wlog[w0], 16'h0010);
         chk("rerun_wdata3", wlog[w0 + 3], 16'h0013);
      end

      // Abort during the read pass after a miscompare keeps the error record.
      repeat (5) @(posedge CLK);
      #1;
      ca = 8'h10;
      mode = 2'd0; addr_lo = 24'h10; addr_hi = 24'h13;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      n = 0;
      while (!(RD_ADR == 24'h12 && rd_start_trig) && n < 300) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("abrd_reach", (n < 300), 1);
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      chk("abrd_running", running, 0);
      chk("abrd_done", done, 0);
      chk("abrd_err_cnt", err_cnt, 1);
      chk("abrd_err_adr", err_adr, 24'h10);
      chk("abrd_err_exp", err_exp, 16'h0010);
      chk("abrd_err_got", err_got, 16'h0000);
      ca = 8'hFF;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
